fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter sharing one FIFO write port among N_REQ requesters on the system bus. Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a bounded burst and drives the FIFO's enq/data_in, honouring full and, optionally, almost_full. It sits directly in front of the shared FIFO instance, and no FIFO logic lives inside it.

## Interface
- N_REQ, 4: number of requesters, 2..16.
- WIDTH, 32: data width; must match the FIFO's WIDTH.
- MAX_BURST, 4: maximum beats per grant, 1..255.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester beat valid.
- req_data  in  N_REQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  N_REQ  per-requester beat accepted; one-hot or zero.
- fifo_enq  out  1  FIFO enqueue strobe.
- fifo_data  out  WIDTH  FIFO write data.
- fifo_full  in  1  FIFO full.
- fifo_almost_full  in  1  FIFO almost_full.
- grant_id  out  $clog2(N_REQ)  currently granted requester; valid while busy.
- busy  out  1  high in GRANT state.

## Operation
- **States**
  - IDLE: no grant held.
  - GRANT: one requester owns the FIFO write port.
- **Round-robin pointer** rr_ptr, $clog2(N_REQ) bits.
  - Search order: rr_ptr, rr_ptr+1, …, wrapping modulo N_REQ.
  - The first asserted req_valid in that order wins.
- **IDLE -> GRANT**
  - Taken when any req_valid is high and the throttle permits (see Configuration).
  - Registers grant_id = winner and beat_cnt = 0.
- **Beat transfer in GRANT** (combinational)
  - beat = req_valid[grant_id] & ~fifo_full.
  - fifo_enq = beat.
  - req_ready[grant_id] = beat; all other req_ready bits are 0.
  - fifo_data = req_data[grant_id] when beat, else 0.
- **Burst counter**
  - beat_cnt increments on each beat; width is $clog2(MAX_BURST+1).
- **GRANT -> IDLE**, on whichever comes first:
  - a beat occurs with beat_cnt == MAX_BURST-1 (the last beat of the burst), or
  - req_valid[grant_id] is low in a cycle (the requester gave up the grant).
  - On exit: rr_ptr <= (grant_id == N_REQ-1) ? 0 : grant_id+1.
- **Full FIFO**: fifo_full high in GRANT stalls the transfer.
  - The grant is held and beat_cnt is unchanged.
  - No beat is issued while full is high.
- **Ownership**: the granted requester keeps ownership until burst end; other requests are not considered.
- **Reset**: an async rstn assertion mid-burst abandons the grant.
  - All outputs go to their reset values immediately.
  - Because fifo_enq is combinational from state, no partial beat is issued.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, beat_cnt 0, grant_id 0, busy 0.
  - req_ready 0, fifo_enq 0, fifo_data 0.
- Grant latency: a request seen in IDLE at edge k gives busy=1 after edge k; the first beat can be accepted in that cycle, before edge k+1.
- Throughput: 1 beat/cycle within a burst.
- Re-arbitration bubble: one IDLE cycle between consecutive grants.
  - Sustained rate for always-valid requesters: MAX_BURST beats per MAX_BURST+1 cycles.
- Handshake: a requester holds req_data stable while req_valid is high and req_ready is low.
  - A beat completes on the clock edge where req_valid and req_ready are both high.

## Configuration
- Macro: FIFO_WR_ARB_AF_THROTTLE_EN.
- **Defined**: the IDLE -> GRANT transition is blocked while fifo_almost_full is high.
  - Bursts already in progress continue and are limited only by fifo_full.
- **Undefined**: fifo_almost_full is ignored.
  - The port remains present and unused, and the interface is identical in both builds.

## Test plan
- **Reset**: rstn low with req_valid=4'b1111.
  - Required: all outputs 0 and no fifo_enq.
  - After release: grant_id=0 on the first edge.
- **Round-robin rotation**: N_REQ=4, MAX_BURST=4, all requesters always valid, FIFO never full.
  - Required: bursts of 4 beats each from requester 0, 1, 2, 3, 0 in that order.
  - Required: one IDLE cycle between bursts, i.e. 16 beats in 20 cycles.
- **Early release**: requester 2 alone valid for 2 beats, then drops.
  - Required: exactly 2 enqs carrying requester 2's data.
  - Required: return to IDLE, with rr_ptr=3 afterwards.
- **Full stall**: fifo_full held high for 3 cycles mid-burst after beat 2.
  - Required: fifo_enq=0 and req_ready=0 during those 3 cycles.
  - Required: grant_id unchanged, and beats 3 and 4 follow once full drops.
- **Mid-burst reset**: rstn asserted asynchronously between beats 1 and 2.
  - Required: fifo_enq falls immediately.
  - After release: arbitration restarts from rr_ptr=0.
- **Throttle**, with FIFO_WR_ARB_AF_THROTTLE_EN defined and almost_full high in IDLE with requesters valid.
  - Required: busy stays 0 until almost_full drops.
  - Without the macro: a grant is issued on the next edge.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N_REQ valid/ready requesters.
// Optional macro FIFO_WR_ARB_AF_THROTTLE_EN blocks new grants while fifo_almost_full is high.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     fifo_enq,
    output logic [WIDTH-1:0]         fifo_data,
    input  logic                     fifo_full,
    input  logic                     fifo_almost_full,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic [ID_W-1:0]  winner;
    logic             any_valid;
    logic             start_ok;
    logic             beat;
    logic             owner_valid;
    logic [WIDTH-1:0] data_arr [N_REQ];
    logic [ID_W-1:0]  idx;
    int               sum;

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        return (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = int'(rr_ptr) + i;
            if (sum >= N_REQ) sum = sum - N_REQ;
            idx = ID_W'(sum);
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
    end

`ifdef FIFO_WR_ARB_AF_THROTTLE_EN
    assign start_ok = ~fifo_almost_full;
`else
    logic unused_almost_full;
    assign unused_almost_full = fifo_almost_full;
    assign start_ok = 1'b1;
`endif

    always_comb begin
        for (int i = 0; i < N_REQ; i++) data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    // Outputs are combinational from registered state, so an async reset kills a beat at once.
    assign owner_valid = req_valid[grant_id];
    assign busy        = (state == GRANT);
    assign beat        = busy & owner_valid & ~fifo_full;
    assign fifo_enq    = beat;
    assign fifo_data   = beat ? data_arr[grant_id] : '0;
    assign req_ready   = beat ? (N_REQ'(1) << grant_id) : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid && start_ok) begin
                        state    <= GRANT;
                        grant_id <= winner;
                        beat_cnt <= '0;
                    end
                end
                default: begin
                    if (!owner_valid || (beat && beat_cnt == LAST_BEAT)) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr(grant_id);
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected FIFO words are queued as bursts are
// anticipated and popped whenever the arbiter enqueues.
module tb_fifo_wr_arbiter;

    localparam int N_REQ     = 4;
    localparam int WIDTH     = 32;
    localparam int MAX_BURST = 4;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_enq;
    logic [WIDTH-1:0]       fifo_data;
    logic                   fifo_full;
    logic                   fifo_almost_full;
    logic [1:0]             grant_id;
    logic                   busy;

    int total = 0;
    int bad   = 0;
    int enq_cnt = 0;
    int seq [N_REQ];
    int exp_seq [N_REQ];
    logic [WIDTH-1:0] sb [$];

    fifo_wr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_enq(fifo_enq), .fifo_data(fifo_data),
        .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] mk(input int id, input int s);
        return {8'hA5, 8'(id), 16'(s)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < N_REQ; i++) req_data[i*WIDTH +: WIDTH] = mk(i, seq[i]);
    endtask

    task automatic push_burst(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            sb.push_back(mk(id, exp_seq[id]));
            exp_seq[id]++;
        end
    endtask

    // One clock cycle: sample at negedge, advance accepted requesters after the posedge.
    task automatic cyc();
        logic [N_REQ-1:0] acc;
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        acc = req_ready & req_valid;
        if (fifo_enq === 1'b1) begin
            enq_cnt++;
            chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_enq observed=%0h expected=none", fifo_data);
            end
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                chk("enq_data", fifo_data, exp);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) if (acc[i]) seq[i]++;
        drive_data();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        for (int i = 0; i < N_REQ; i++) begin seq[i] = 0; exp_seq[i] = 0; end
        rstn = 1'b0;
        req_valid = 4'b1111;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;
        drive_data();
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_enq", 32'(fifo_enq), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_data", fifo_data, 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_busy", 32'(busy), 32'd1);
        chk("rel_grant", 32'(grant_id), 32'd0);

        // Rotation 0,1,2,3,0 with one idle cycle between bursts.
        push_burst(0, 4); push_burst(1, 4); push_burst(2, 4); push_burst(3, 4); push_burst(0, 4);
        e0 = enq_cnt;
        for (int c = 1; c <= 24; c++) begin
            chk("rot_busy", 32'(busy), (c % 5 == 0) ? 32'd0 : 32'd1);
            cyc();
            if (c == 20) chk("rot_16_in_20", 32'(enq_cnt - e0), 32'd16);
        end
        chk("rot_drain", 32'(sb.size()), 32'd0);
        req_valid = 4'b0000;
        cyc();

        // Early release by requester 2; pointer moves to 3.
        req_valid = 4'b0100;
        #1 chk("er_idle", 32'(busy), 32'd0);
        cyc();
        chk("er_grant", 32'(grant_id), 32'd2);
        push_burst(2, 2);
        e0 = enq_cnt;
        cyc(); cyc();
        req_valid = 4'b0000;
        #1 chk("er_drop_enq", 32'(fifo_enq), 32'd0);
        cyc();
        chk("er_idle_after", 32'(busy), 32'd0);
        chk("er_enqs", 32'(enq_cnt - e0), 32'd2);
        req_valid = 4'b1111;
        cyc();
        chk("er_rr_next", 32'(grant_id), 32'd3);

        // Full stall after beat 2 of requester 3's burst.
        push_burst(3, 4);
        cyc(); cyc();
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("full_enq", 32'(fifo_enq), 32'd0);
            chk("full_ready", 32'(req_ready), 32'd0);
            chk("full_grant", 32'(grant_id), 32'd3);
            cyc();
        end
        fifo_full = 1'b0;
        #1 chk("full_resume", 32'(fifo_enq), 32'd1);
        cyc(); cyc();
        chk("full_drain", 32'(sb.size()), 32'd0);
        chk("full_end_idle", 32'(busy), 32'd0);

        // Move the pointer past 0, then reset in the middle of requester 1's burst.
        cyc();
        push_burst(0, 4);
        repeat (4) cyc();
        cyc();
        chk("pre_rst_grant", 32'(grant_id), 32'd1);
        push_burst(1, 1);
        cyc();
        #1 chk("pre_rst_enq", 32'(fifo_enq), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("mrst_enq", 32'(fifo_enq), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd0);
        chk("mrst_data", fifo_data, 32'd0);
        chk("mrst_grant", 32'(grant_id), 32'd0);
        chk("mrst_drain", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_restart", 32'(grant_id), 32'd0);
        chk("mrst_restart_busy", 32'(busy), 32'd1);
        push_burst(0, 4);
        repeat (4) cyc();
        req_valid = 4'b0000;
        cyc();

        // almost_full while idle with requesters waiting.
        fifo_almost_full = 1'b1;
        req_valid = 4'b1111;
        #1 chk("af_idle", 32'(busy), 32'd0);
        cyc();
`ifdef FIFO_WR_ARB_AF_THROTTLE_EN
        chk("af_blocked", 32'(busy), 32'd0);
        cyc();
        chk("af_blocked2", 32'(busy), 32'd0);
        fifo_almost_full = 1'b0;
        cyc();
`endif
        chk("af_grant_busy", 32'(busy), 32'd1);
        chk("af_grant_id", 32'(grant_id), 32'd1);
        push_burst(1, 4);
        repeat (4) cyc();
        chk("af_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
